csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control and status register file for the RV64 core, instantiated once per hart between decode/execute and the PC-select logic. It serves CSR read/modify/write instructions, tracks privilege level, records trap state on exception/interrupt entry, restores it on `mret`, and runs the free-running cycle counter. Compared with the fixed register set it succeeds, the number of PMP entries and the hart ID are parametrised, and vectored trap dispatch is added.

## Interface
- `MXLEN`, 64: register width; only 64 is supported.
- `PMP_ENTRIES`, 4: number of `pmpaddrN` registers, 1..16; only `pmpcfg0` exists.
- `HARTID`, 0: constant returned by `mhartid`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  pipeline stall; while high, only `mcycle` changes.
- `csr_valid`  in  1  CSR instruction present this cycle.
- `csr_op`  in  2  01 RW, 10 RS, 11 RC; 00 is read-only.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  MXLEN  rs1 or zimm operand.
- `csr_rdata`  out  MXLEN  pre-update value, combinational.
- `csr_illegal`  out  1  combinational illegal-access flag.
- `trap_valid`  in  1  trap entry request.
- `trap_cause`  in  MXLEN  mcause value; bit 63 set means interrupt.
- `trap_pc`  in  MXLEN  faulting PC.
- `trap_tval`  in  MXLEN  mtval value.
- `mret_valid`  in  1  `mret` retire.
- `irq_ext`, `irq_timer`, `irq_sw`  in  1 each  drive `mip` bits 11, 7 and 3.
- `irq_pending`  out  1  an enabled interrupt is pending.
- `redirect_valid`  out  1  registered PC redirect pulse.
- `redirect_pc`  out  MXLEN  registered redirect target.
- `priv`  out  2  current privilege level: 0 U, 1 S, 3 M.
- `mstatus_o`, `satp_o`  out  MXLEN  live register values.
- `pmpaddr_o`  out  PMP_ENTRIES*MXLEN  flattened PMP addresses, entry 0 in the LSBs.

## Operation
- Registers: `mstatus`, `mtvec`, `mepc`, `mcause`, `mtval`, `mscratch`, `mie`, `mip`, `mcycle`, `satp`, `pmpcfg0`, `pmpaddr[PMP_ENTRIES]`.
  - `mhartid` is read-only and returns HARTID.
  - `medeleg`/`mideleg` read 0; writes to them are ignored.
  - S-level CSRs (`stvec`, `sscratch`, `sepc`, `scause`, `stval`) are plain storage registers.
  - `sstatus`, `sie` and `sip` are masked views: `sstatus` is `mstatus` & 0x800000030001e000.
- Write value: `csr_wdata` for RW, `old|wdata` for RS, `old&~wdata` for RC. Then `new = (old & ~MASK) | (wv & MASK)`, with these masks:
  - `mstatus` 0x7e79bb.
  - `mip` 0x333; bits 11, 7 and 3 always follow the irq inputs.
  - `mtvec` ~2.
  - All other registers: all ones.
- Illegal access (no state change, `csr_illegal`=1) when any of these holds:
  - the address is unimplemented;
  - the op is not 00 and `addr[11:10]`=11;
  - `priv` < `addr[9:8]`.
- Trap entry, committed at the clock edge:
  - `mepc`←`trap_pc`, `mcause`←`trap_cause`, `mtval`←`trap_tval`.
  - MPIE←MIE, MIE←0, MPP←`priv`, `priv`←3.
- `mret`: `priv`←MPP, MIE←MPIE, MPIE←1, MPP←0. Redirect target is `mepc`.
- `irq_pending` = `|(mip & mie)` && (`priv`!=3 || MIE).
- `mcycle` increments every cycle and wraps from 2^64−1 to 0. A CSR write to `mcycle` replaces that cycle's increment.
- Priority when events coincide: `trap_valid` > `mret_valid` > CSR write. Losing events are dropped without error.
- `stall` suppresses trap, `mret` and CSR updates; the redirect pulse is not generated.

## Timing
- Reset values:
  - `priv`=3.
  - All registers 0; `mhartid` reads HARTID.
  - `redirect_valid`=0, `redirect_pc`=0.
  - `csr_illegal`/`irq_pending` follow the zeroed state.
- Reads are 0-latency. Writes are visible on `csr_rdata` and the `*_o` outputs the cycle after the edge.
- `redirect_valid` pulses exactly one cycle, the cycle after the accepted trap or `mret`. `redirect_pc` holds its value until the next redirect.
- Reset mid-operation clears everything immediately, including a pending redirect pulse.

## Configuration
- `CSR_VECTORED_EN` defined:
  - `mtvec[1:0]`=01 selects vectored mode.
  - Interrupt traps redirect to `(mtvec&~3)+4*cause[5:0]`.
  - Exceptions always go to `mtvec&~3`.
- Undefined:
  - Writes force `mtvec[1:0]` to 0.
  - All traps redirect to `mtvec&~3`.

## Structure
- Shared `csr_pkg` holds:
  - CSR addresses and write masks;
  - the `mstatus_t`/`satp_t` structs;
  - new `csr_op_t` and `priv_t` enums;
  - `PMP_MAX`=16;
  - `MIP_HW_MASK`=0x888.
- One sub-module, `csr_trap_ctrl`: owns the trap/`mret` priority, the next-state computation for `mstatus`/`priv`, and the registered redirect outputs.

## Test plan
- Reset, then read `mstatus`, `mtvec` and `mhartid` (HARTID=5) → 0, 0, 5; `priv`=3.
- RW `mstatus`←all-ones → reads 0x7e79bb. RC 0x8 → reads 0x7e79b3.
- `trap_valid` with cause 2, pc 0x8000_0010, `mtvec`=0x8000_0100 → next cycle `redirect_valid`=1 and `redirect_pc`=0x8000_0100, `mepc`=0x8000_0010, MPP=3, MIE=0.
- With CSR_VECTORED_EN, `mtvec`=0x8000_0101, cause 0x8000…0007 → `redirect_pc`=0x8000_011c. Without the macro, `mtvec` reads 0x8000_0100.
- `trap_valid`, `mret_valid` and a CSR write in the same cycle → only the trap is applied; the CSR value is unchanged.
- `mcycle`←0xFFFF…FFFE → reads …FFFF, then 0 on the following cycle. U-mode write to `mscratch` → `csr_illegal`=1 and the value is unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, write masks, register layouts and helpers.
// CSR_VECTORED_EN enables vectored mtvec dispatch.
package csr_pkg;

  localparam int XLEN    = 64;
  localparam int PMP_MAX = 16;

  typedef enum logic [1:0] {
    CSR_RO = 2'b00,
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_t;

  typedef struct packed {
    logic        sd;
    logic [24:0] wpri38;
    logic        mbe;
    logic        sbe;
    logic [1:0]  sxl;
    logic [1:0]  uxl;
    logic [8:0]  wpri23;
    logic        tsr;
    logic        tw;
    logic        tvm;
    logic        mxr;
    logic        sum;
    logic        mprv;
    logic [1:0]  xs;
    logic [1:0]  fs;
    logic [1:0]  mpp;
    logic [1:0]  vs;
    logic        spp;
    logic        mpie;
    logic        ube;
    logic        spie;
    logic        wpri4;
    logic        mie;
    logic        wpri2;
    logic        sie;
    logic        wpri0;
  } mstatus_t;

  typedef struct packed {
    logic [3:0]  mode;
    logic [15:0] asid;
    logic [43:0] ppn;
  } satp_t;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_SIE      = 12'h104;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_SIP      = 12'h144;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_PMPCFG0  = 12'h3a0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3b0;
  localparam logic [11:0] CSR_MCYCLE   = 12'hb00;
  localparam logic [11:0] CSR_MHARTID  = 12'hf14;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = 64'h0000_0000_007e_79bb;
  localparam logic [XLEN-1:0] SSTATUS_MASK  = 64'h8000_0003_0001_e000;
  localparam logic [XLEN-1:0] MIP_WMASK     = 64'h0000_0000_0000_0333;
  localparam logic [XLEN-1:0] MIP_HW_MASK   = 64'h0000_0000_0000_0888;
  localparam logic [XLEN-1:0] SINT_MASK     = 64'h0000_0000_0000_0222;
`ifdef CSR_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_WMASK   = ~64'h2;
`else
  localparam logic [XLEN-1:0] MTVEC_WMASK   = ~64'h3;
`endif

  function automatic logic [XLEN-1:0] csr_wval(
    input csr_op_t         op,
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] wdata
  );
    logic [XLEN-1:0] v;
    v = old;
    unique case (op)
      CSR_RW:  v = wdata;
      CSR_RS:  v = old | wdata;
      CSR_RC:  v = old & ~wdata;
      default: v = old;
    endcase
    return v;
  endfunction

  function automatic logic [XLEN-1:0] csr_merge(
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] wv,
    input logic [XLEN-1:0] mask
  );
    return (old & ~mask) | (wv & mask);
  endfunction

  // MPP=10 is reserved; treat it as U on return
  function automatic priv_t to_priv(input logic [1:0] p);
    priv_t r;
    unique case (p)
      2'b11:   r = PRIV_M;
      2'b01:   r = PRIV_S;
      default: r = PRIV_U;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap/mret arbitration, mstatus/priv next state and the
// registered PC redirect.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int MXLEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             trap_valid,
  input  logic             mret_valid,
  input  priv_t            priv_q,
  input  mstatus_t         mstatus_q,
  input  mstatus_t         mstatus_csr,
  input  logic [MXLEN-1:0] tvec_target,
  input  logic [MXLEN-1:0] mepc_q,
  output logic             trap_take,
  output mstatus_t         mstatus_d,
  output priv_t            priv_d,
  output logic             redirect_valid,
  output logic [MXLEN-1:0] redirect_pc
);

  logic             mret_take;
  logic             redirect_valid_d, redirect_valid_q;
  logic [MXLEN-1:0] redirect_pc_d, redirect_pc_q;

  always_comb begin
    trap_take        = trap_valid && !stall;
    mret_take        = mret_valid && !trap_valid && !stall;
    mstatus_d        = mstatus_csr;
    priv_d           = priv_q;
    redirect_valid_d = trap_take || mret_take;
    redirect_pc_d    = redirect_pc_q;
    unique case (1'b1)
      trap_take: begin
        mstatus_d      = mstatus_q;
        mstatus_d.mpie = mstatus_q.mie;
        mstatus_d.mie  = 1'b0;
        mstatus_d.mpp  = priv_q;
        priv_d         = PRIV_M;
        redirect_pc_d  = tvec_target;
      end
      mret_take: begin
        mstatus_d      = mstatus_q;
        mstatus_d.mie  = mstatus_q.mpie;
        mstatus_d.mpie = 1'b1;
        mstatus_d.mpp  = 2'b00;
        priv_d         = to_priv(mstatus_q.mpp);
        redirect_pc_d  = mepc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR access, trap state, mcycle.
// Define CSR_VECTORED_EN for vectored interrupt dispatch.
module csr_file
  import csr_pkg::*;
#(
  parameter int MXLEN       = 64,
  parameter int PMP_ENTRIES = 4,
  parameter int HARTID      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         csr_valid,
  input  logic [1:0]                   csr_op,
  input  logic [11:0]                  csr_addr,
  input  logic [MXLEN-1:0]             csr_wdata,
  output logic [MXLEN-1:0]             csr_rdata,
  output logic                         csr_illegal,
  input  logic                         trap_valid,
  input  logic [MXLEN-1:0]             trap_cause,
  input  logic [MXLEN-1:0]             trap_pc,
  input  logic [MXLEN-1:0]             trap_tval,
  input  logic                         mret_valid,
  input  logic                         irq_ext,
  input  logic                         irq_timer,
  input  logic                         irq_sw,
  output logic                         irq_pending,
  output logic                         redirect_valid,
  output logic [MXLEN-1:0]             redirect_pc,
  output logic [1:0]                   priv,
  output logic [MXLEN-1:0]             mstatus_o,
  output logic [MXLEN-1:0]             satp_o,
  output logic [PMP_ENTRIES*MXLEN-1:0] pmpaddr_o
);

  mstatus_t mstatus_q, mstatus_d, mstatus_csr;
  priv_t    priv_q, priv_d;
  satp_t    satp_q, satp_d;

  logic [MXLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [MXLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [MXLEN-1:0] mscratch_q, mscratch_d, mie_q, mie_d;
  logic [MXLEN-1:0] mip_q, mip_d, mcycle_q, mcycle_d;
  logic [MXLEN-1:0] pmpcfg0_q, pmpcfg0_d, stvec_q, stvec_d;
  logic [MXLEN-1:0] sscratch_q, sscratch_d, sepc_q, sepc_d;
  logic [MXLEN-1:0] scause_q, scause_d, stval_q, stval_d;
  logic [MXLEN-1:0] pmpaddr_q [PMP_ENTRIES];
  logic [MXLEN-1:0] pmpaddr_d [PMP_ENTRIES];

  logic [MXLEN-1:0] mip_rd, wv, vec_off, tvec_target;
  logic             impl, csr_we, trap_take;

  // hardware interrupt lines override the stored mip bits
  assign mip_rd = (mip_q & ~MIP_HW_MASK)
                | {52'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    unique case (csr_addr)
      CSR_SSTATUS:  csr_rdata = mstatus_q & SSTATUS_MASK;
      CSR_SIE:      csr_rdata = mie_q & SINT_MASK;
      CSR_STVEC:    csr_rdata = stvec_q;
      CSR_SSCRATCH: csr_rdata = sscratch_q;
      CSR_SEPC:     csr_rdata = sepc_q;
      CSR_SCAUSE:   csr_rdata = scause_q;
      CSR_STVAL:    csr_rdata = stval_q;
      CSR_SIP:      csr_rdata = mip_rd & SINT_MASK;
      CSR_SATP:     csr_rdata = satp_q;
      CSR_MSTATUS:  csr_rdata = mstatus_q;
      CSR_MEDELEG:  csr_rdata = '0;
      CSR_MIDELEG:  csr_rdata = '0;
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip_rd;
      CSR_PMPCFG0:  csr_rdata = pmpcfg0_q;
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MHARTID:  csr_rdata = MXLEN'(HARTID);
      default:      impl = 1'b0;
    endcase
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (csr_addr == CSR_PMPADDR0 + 12'(i)) begin
        csr_rdata = pmpaddr_q[i];
        impl      = 1'b1;
      end
    end
  end

  assign csr_illegal = csr_valid &&
    (!impl ||
     (csr_op != CSR_RO && csr_addr[11:10] == 2'b11) ||
     (priv_q < csr_addr[9:8]));

  assign csr_we = csr_valid && csr_op != CSR_RO && !csr_illegal &&
                  !stall && !trap_valid && !mret_valid;

  always_comb begin
    wv          = csr_wval(csr_op_t'(csr_op), csr_rdata, csr_wdata);
    mstatus_csr = mstatus_q;
    satp_d      = satp_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mscratch_d  = mscratch_q;
    mie_d       = mie_q;
    mip_d       = mip_q;
    mcycle_d    = mcycle_q + MXLEN'(1);
    pmpcfg0_d   = pmpcfg0_q;
    stvec_d     = stvec_q;
    sscratch_d  = sscratch_q;
    sepc_d      = sepc_q;
    scause_d    = scause_q;
    stval_d     = stval_q;
    pmpaddr_d   = pmpaddr_q;
    if (csr_we) begin
      unique case (csr_addr)
        CSR_SSTATUS:  mstatus_csr = mstatus_t'(csr_merge(mstatus_q, wv,
                                      MSTATUS_WMASK & SSTATUS_MASK));
        CSR_SIE:      mie_d      = csr_merge(mie_q, wv, SINT_MASK);
        CSR_STVEC:    stvec_d    = wv;
        CSR_SSCRATCH: sscratch_d = wv;
        CSR_SEPC:     sepc_d     = wv;
        CSR_SCAUSE:   scause_d   = wv;
        CSR_STVAL:    stval_d    = wv;
        CSR_SIP:      mip_d      = csr_merge(mip_q, wv, MIP_WMASK & SINT_MASK);
        CSR_SATP:     satp_d     = satp_t'(wv);
        CSR_MSTATUS:  mstatus_csr = mstatus_t'(csr_merge(mstatus_q, wv,
                                      MSTATUS_WMASK));
        CSR_MIE:      mie_d      = wv;
        CSR_MTVEC:    mtvec_d    = csr_merge(mtvec_q, wv, MTVEC_WMASK);
        CSR_MSCRATCH: mscratch_d = wv;
        CSR_MEPC:     mepc_d     = wv;
        CSR_MCAUSE:   mcause_d   = wv;
        CSR_MTVAL:    mtval_d    = wv;
        CSR_MIP:      mip_d      = csr_merge(mip_q, wv, MIP_WMASK);
        CSR_PMPCFG0:  pmpcfg0_d  = wv;
        CSR_MCYCLE:   mcycle_d   = wv;
        default: ;
      endcase
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (csr_addr == CSR_PMPADDR0 + 12'(i)) pmpaddr_d[i] = wv;
      end
    end
    if (trap_take) begin
      mepc_d   = trap_pc;
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
    end
  end

`ifdef CSR_VECTORED_EN
  assign vec_off = (mtvec_q[1:0] == 2'b01 && trap_cause[MXLEN-1])
                 ? MXLEN'({trap_cause[5:0], 2'b00}) : '0;
`else
  assign vec_off = '0;
`endif
  assign tvec_target = {mtvec_q[MXLEN-1:2], 2'b00} + vec_off;

  csr_trap_ctrl #(.MXLEN(MXLEN)) u_trap (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .trap_valid     (trap_valid),
    .mret_valid     (mret_valid),
    .priv_q         (priv_q),
    .mstatus_q      (mstatus_q),
    .mstatus_csr    (mstatus_csr),
    .tvec_target    (tvec_target),
    .mepc_q         (mepc_q),
    .trap_take      (trap_take),
    .mstatus_d      (mstatus_d),
    .priv_d         (priv_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_q  <= '0;
      priv_q     <= PRIV_M;
      satp_q     <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mie_q      <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      pmpcfg0_q  <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
      for (int i = 0; i < PMP_ENTRIES; i++) pmpaddr_q[i] <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      priv_q     <= priv_d;
      satp_q     <= satp_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mcycle_q   <= mcycle_d;
      pmpcfg0_q  <= pmpcfg0_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      stval_q    <= stval_d;
      for (int i = 0; i < PMP_ENTRIES; i++) pmpaddr_q[i] <= pmpaddr_d[i];
    end
  end

  assign irq_pending = |(mip_rd & mie_q) && (priv_q != PRIV_M || mstatus_q.mie);
  assign priv        = priv_q;
  assign mstatus_o   = mstatus_q;
  assign satp_o      = satp_q;

  for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_pmp
    assign pmpaddr_o[g*MXLEN +: MXLEN] = pmpaddr_q[g];
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file (HARTID=5, 4 PMP entries).
module tb_csr_file;

  logic         clk = 1'b0;
  logic         reset, stall, csr_valid;
  logic [1:0]   csr_op;
  logic [11:0]  csr_addr;
  logic [63:0]  csr_wdata, csr_rdata;
  logic         csr_illegal;
  logic         trap_valid, mret_valid;
  logic [63:0]  trap_cause, trap_pc, trap_tval;
  logic         irq_ext, irq_timer, irq_sw, irq_pending;
  logic         redirect_valid;
  logic [63:0]  redirect_pc, mstatus_o, satp_o;
  logic [1:0]   priv;
  logic [255:0] pmpaddr_o;

  int          checks = 0;
  int          failures = 0;
  logic        last_ill;
  logic [63:0] rd, rd2;

  csr_file #(.MXLEN(64), .PMP_ENTRIES(4), .HARTID(5)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .irq_pending(irq_pending), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .priv(priv), .mstatus_o(mstatus_o),
    .satp_o(satp_o), .pmpaddr_o(pmpaddr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive_idle();
    stall = 0; csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    mret_valid = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a,
                        input logic [63:0] d);
    @(negedge clk);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    #1 last_ill = csr_illegal;
    @(posedge clk);
    #1 csr_valid = 0; csr_op = 0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [63:0] v);
    @(negedge clk);
    csr_valid = 1; csr_op = 0; csr_addr = a;
    #1 v = csr_rdata; last_ill = csr_illegal;
    csr_valid = 0;
  endtask

  task automatic fire_trap(input logic [63:0] c, input logic [63:0] pc,
                           input logic [63:0] tv);
    @(negedge clk);
    trap_valid = 1; trap_cause = c; trap_pc = pc; trap_tval = tv;
    @(posedge clk);
    #1 trap_valid = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    #1;
    checks++; if (priv !== 2'd3) begin failures++; $display("FAIL reset_priv got=%0h exp=3", priv); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 64'h0) begin failures++; $display("FAIL reset_rpc got=%0h exp=0", redirect_pc); end
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq_pending); end
    @(negedge clk);
    reset = 0;
    csr_rd(12'h300, rd);
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL reset_mstatus got=%0h exp=0", rd); end
    csr_rd(12'h305, rd);
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL reset_mtvec got=%0h exp=0", rd); end
    csr_rd(12'hf14, rd);
    checks++; if (rd !== 64'h5) begin failures++; $display("FAIL reset_mhartid got=%0h exp=5", rd); end
  endtask

  task automatic test_mstatus_mask();
    do_reset();
    csr_wr(2'b01, 12'h300, '1);
    csr_rd(12'h300, rd);
    checks++; if (rd !== 64'h7e79bb) begin failures++; $display("FAIL ms_rw got=%0h exp=7e79bb", rd); end
    checks++; if (mstatus_o !== 64'h7e79bb) begin failures++; $display("FAIL ms_o got=%0h exp=7e79bb", mstatus_o); end
    csr_wr(2'b11, 12'h300, 64'h8);
    csr_rd(12'h300, rd);
    checks++; if (rd !== 64'h7e79b3) begin failures++; $display("FAIL ms_rc got=%0h exp=7e79b3", rd); end
    csr_rd(12'h100, rd);
    checks++; if (rd !== 64'h6000) begin failures++; $display("FAIL sstatus got=%0h exp=6000", rd); end
    csr_wr(2'b01, 12'h302, '1);
    csr_rd(12'h302, rd);
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL medeleg got=%0h exp=0", rd); end
  endtask

  task automatic test_trap();
    do_reset();
    csr_wr(2'b01, 12'h305, 64'h8000_0100);
    csr_wr(2'b10, 12'h300, 64'h8);
    fire_trap(64'h2, 64'h8000_0010, 64'h1234);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL trap_rv got=%0b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0100) begin failures++; $display("FAIL trap_rpc got=%0h exp=80000100", redirect_pc); end
    @(posedge clk); #1;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL trap_pulse got=%0b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0100) begin failures++; $display("FAIL trap_hold got=%0h exp=80000100", redirect_pc); end
    csr_rd(12'h341, rd);
    checks++; if (rd !== 64'h8000_0010) begin failures++; $display("FAIL trap_mepc got=%0h exp=80000010", rd); end
    csr_rd(12'h342, rd);
    checks++; if (rd !== 64'h2) begin failures++; $display("FAIL trap_mcause got=%0h exp=2", rd); end
    csr_rd(12'h343, rd);
    checks++; if (rd !== 64'h1234) begin failures++; $display("FAIL trap_mtval got=%0h exp=1234", rd); end
    checks++; if (mstatus_o !== 64'h1880) begin failures++; $display("FAIL trap_ms got=%0h exp=1880", mstatus_o); end
    checks++; if (priv !== 2'd3) begin failures++; $display("FAIL trap_priv got=%0h exp=3", priv); end
  endtask

  task automatic test_mret_umode();
    csr_wr(2'b01, 12'h340, 64'hdead_beef);
    csr_wr(2'b11, 12'h300, 64'h1800);
    @(negedge clk);
    mret_valid = 1;
    @(posedge clk);
    #1 mret_valid = 0;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL mret_rv got=%0b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0010) begin failures++; $display("FAIL mret_rpc got=%0h exp=80000010", redirect_pc); end
    checks++; if (priv !== 2'd0) begin failures++; $display("FAIL mret_priv got=%0h exp=0", priv); end
    checks++; if (mstatus_o !== 64'h88) begin failures++; $display("FAIL mret_ms got=%0h exp=88", mstatus_o); end
    csr_wr(2'b01, 12'h340, 64'h1111);
    checks++; if (last_ill !== 1'b1) begin failures++; $display("FAIL umode_ill got=%0b exp=1", last_ill); end
    fire_trap(64'h8, 64'h40, 64'h0);
    checks++; if (priv !== 2'd3) begin failures++; $display("FAIL utrap_priv got=%0h exp=3", priv); end
    checks++; if (mstatus_o !== 64'h80) begin failures++; $display("FAIL utrap_ms got=%0h exp=80", mstatus_o); end
    csr_rd(12'h340, rd);
    checks++; if (rd !== 64'hdead_beef) begin failures++; $display("FAIL umode_keep got=%0h exp=deadbeef", rd); end
  endtask

  task automatic test_irq();
    do_reset();
    csr_wr(2'b01, 12'h304, 64'h80);
    irq_timer = 1;
    #1;
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_masked got=%0b exp=0", irq_pending); end
    csr_rd(12'h344, rd);
    checks++; if (rd !== 64'h80) begin failures++; $display("FAIL irq_mip got=%0h exp=80", rd); end
    csr_wr(2'b10, 12'h300, 64'h8);
    checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL irq_on got=%0b exp=1", irq_pending); end
    irq_timer = 0;
    #1;
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_off got=%0b exp=0", irq_pending); end
  endtask

  task automatic test_vectored();
    logic [63:0] exp_tv, exp_pc;
`ifdef CSR_VECTORED_EN
    exp_tv = 64'h8000_0101;
    exp_pc = 64'h8000_011c;
`else
    exp_tv = 64'h8000_0100;
    exp_pc = 64'h8000_0100;
`endif
    do_reset();
    csr_wr(2'b01, 12'h305, 64'h8000_0101);
    csr_rd(12'h305, rd);
    checks++; if (rd !== exp_tv) begin failures++; $display("FAIL vec_mtvec got=%0h exp=%0h", rd, exp_tv); end
    fire_trap(64'h8000_0000_0000_0007, 64'h200, 64'h0);
    checks++; if (redirect_pc !== exp_pc) begin failures++; $display("FAIL vec_irq got=%0h exp=%0h", redirect_pc, exp_pc); end
    fire_trap(64'h2, 64'h204, 64'h0);
    checks++; if (redirect_pc !== 64'h8000_0100) begin failures++; $display("FAIL vec_exc got=%0h exp=80000100", redirect_pc); end
  endtask

  task automatic test_priority();
    do_reset();
    csr_wr(2'b01, 12'h305, 64'h8000_0100);
    csr_wr(2'b01, 12'h341, 64'h999);
    csr_wr(2'b01, 12'h340, 64'h77);
    @(negedge clk);
    trap_valid = 1; trap_cause = 64'h5; trap_pc = 64'h300;
    mret_valid = 1;
    csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'h5555;
    @(posedge clk);
    #1 trap_valid = 0; mret_valid = 0; csr_valid = 0; csr_op = 0;
    checks++; if (redirect_pc !== 64'h8000_0100) begin failures++; $display("FAIL prio_rpc got=%0h exp=80000100", redirect_pc); end
    checks++; if (mstatus_o !== 64'h1800) begin failures++; $display("FAIL prio_ms got=%0h exp=1800", mstatus_o); end
    csr_rd(12'h340, rd);
    checks++; if (rd !== 64'h77) begin failures++; $display("FAIL prio_csr got=%0h exp=77", rd); end
    csr_rd(12'h341, rd);
    checks++; if (rd !== 64'h300) begin failures++; $display("FAIL prio_mepc got=%0h exp=300", rd); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    stall = 1;
    trap_valid = 1; trap_cause = 64'h3; trap_pc = 64'h44;
    csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'h99;
    @(posedge clk);
    #1 trap_valid = 0; csr_valid = 0; csr_op = 0;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL stall_rv got=%0b exp=0", redirect_valid); end
    csr_rd(12'h341, rd);
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL stall_mepc got=%0h exp=0", rd); end
    csr_rd(12'h340, rd);
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL stall_csr got=%0h exp=0", rd); end
    csr_rd(12'hb00, rd);
    csr_rd(12'hb00, rd2);
    checks++; if (rd2 !== rd + 64'h1) begin failures++; $display("FAIL stall_mcycle got=%0h exp=%0h", rd2, rd + 64'h1); end
    stall = 0;
  endtask

  task automatic test_mcycle();
    do_reset();
    csr_wr(2'b01, 12'hb00, 64'hffff_ffff_ffff_fffe);
    csr_valid = 1; csr_op = 0; csr_addr = 12'hb00;
    #1;
    checks++; if (csr_rdata !== 64'hffff_ffff_ffff_fffe) begin failures++; $display("FAIL mcyc_wr got=%0h exp=fffffffffffffffe", csr_rdata); end
    @(posedge clk); #1;
    checks++; if (csr_rdata !== 64'hffff_ffff_ffff_ffff) begin failures++; $display("FAIL mcyc_max got=%0h exp=ffffffffffffffff", csr_rdata); end
    @(posedge clk); #1;
    checks++; if (csr_rdata !== 64'h0) begin failures++; $display("FAIL mcyc_wrap got=%0h exp=0", csr_rdata); end
    csr_valid = 0;
  endtask

  task automatic test_pmp_misc();
    do_reset();
    csr_wr(2'b01, 12'h3b3, 64'habc);
    checks++; if (pmpaddr_o[255:192] !== 64'habc) begin failures++; $display("FAIL pmp3 got=%0h exp=abc", pmpaddr_o[255:192]); end
    checks++; if (pmpaddr_o[63:0] !== 64'h0) begin failures++; $display("FAIL pmp0 got=%0h exp=0", pmpaddr_o[63:0]); end
    csr_wr(2'b01, 12'h3b4, 64'h1);
    checks++; if (last_ill !== 1'b1) begin failures++; $display("FAIL pmp4_ill got=%0b exp=1", last_ill); end
    csr_wr(2'b01, 12'hf14, 64'h1);
    checks++; if (last_ill !== 1'b1) begin failures++; $display("FAIL ro_ill got=%0b exp=1", last_ill); end
    csr_rd(12'hf14, rd);
    checks++; if (rd !== 64'h5) begin failures++; $display("FAIL hartid_keep got=%0h exp=5", rd); end
    csr_rd(12'h7c0, rd);
    checks++; if (last_ill !== 1'b1) begin failures++; $display("FAIL unimpl_ill got=%0b exp=1", last_ill); end
    csr_wr(2'b01, 12'h180, 64'h8000_0000_0000_1234);
    checks++; if (satp_o !== 64'h8000_0000_0000_1234) begin failures++; $display("FAIL satp got=%0h exp=8000000000001234", satp_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    csr_wr(2'b01, 12'h305, 64'h100);
    fire_trap(64'h2, 64'h10, 64'h0);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b exp=1", redirect_valid); end
    reset = 1;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL mid_rv got=%0b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 64'h0) begin failures++; $display("FAIL mid_rpc got=%0h exp=0", redirect_pc); end
    checks++; if (mstatus_o !== 64'h0) begin failures++; $display("FAIL mid_ms got=%0h exp=0", mstatus_o); end
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_mstatus_mask();
    test_trap();
    test_mret_umode();
    test_irq();
    test_vectored();
    test_priority();
    test_stall();
    test_mcycle();
    test_pmp_misc();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
